// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 responder backed by a byte-strobed word RAM
module axi_sram_slave #(
  parameter int ADDR_W   = 12,
  parameter int RD_DELAY = 1,
  parameter int B_DELAY  = 0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_BWAIT, W_RESP} w_state_t;

  localparam logic [7:0] RD_DLY_INIT = (RD_DELAY > 0) ? 8'(RD_DELAY - 1) : 8'd0;
  localparam logic [7:0] B_DLY_INIT  = (B_DELAY > 0) ? 8'(B_DELAY - 1) : 8'd0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  logic unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  r_state_t    r_state, r_next;
  logic [3:0]  r_id;
  logic [31:0] r_addr, r_addr_nxt, rdata_q;
  logic [7:0]  r_len, r_cnt, r_dly;
  logic [2:0]  r_size;
  logic        r_incr, r_err, ar_err, ar_hs, r_hs;

  w_state_t    w_state, w_next;
  logic [3:0]  w_id;
  logic [31:0] w_addr, w_addr_nxt;
  logic [7:0]  w_len, w_cnt, w_dly;
  logic [2:0]  w_size;
  logic        w_incr, w_err, w_mism, aw_hs, w_hs, w_hit, w_end;

  // Every handshake output is forced low while reset is held.
  always_comb begin
    arready    = (r_state == R_IDLE) && !areset;
    rvalid     = (r_state == R_DATA) && !areset;
    rlast      = rvalid && (r_cnt == r_len);
    rid        = rvalid ? r_id : 4'd0;
    rdata      = rvalid ? rdata_q : 32'd0;
    rresp      = (rvalid && r_err) ? 2'b10 : 2'b00;
    ar_hs      = arvalid && arready;
    r_hs       = rvalid && rready;
    ar_err     = arburst[1] || (arlen > 8'd15);
    r_addr_nxt = r_incr ? r_addr + (32'd1 << r_size) : r_addr;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = (RD_DELAY == 0) ? R_DATA : R_WAIT;
      R_WAIT:  if (r_dly == 8'd0) r_next = R_DATA;
      R_DATA:  if (r_hs && rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  // rdata_q is loaded one edge ahead of the beat it presents, so a write to
  // the same word at that edge is not seen by the read.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_id <= 4'd0; r_addr <= 32'd0; r_len <= 8'd0; r_size <= 3'd0;
      r_incr <= 1'b0; r_err <= 1'b0; r_cnt <= 8'd0; r_dly <= 8'd0;
      rdata_q <= 32'd0;
    end else if (ar_hs) begin
      r_id <= arid; r_addr <= araddr; r_len <= arlen; r_size <= arsize;
      r_incr <= (arburst == 2'b01); r_err <= ar_err; r_cnt <= 8'd0;
      r_dly <= RD_DLY_INIT;
      if (RD_DELAY == 0) rdata_q <= ar_err ? 32'd0 : mem[araddr[ADDR_W+1:2]];
    end else if (r_state == R_WAIT) begin
      if (r_dly == 8'd0) rdata_q <= r_err ? 32'd0 : mem[r_addr[ADDR_W+1:2]];
      else               r_dly <= r_dly - 8'd1;
    end else if (r_hs && !rlast) begin
      r_cnt   <= r_cnt + 8'd1;
      r_addr  <= r_addr_nxt;
      rdata_q <= r_err ? 32'd0 : mem[r_addr_nxt[ADDR_W+1:2]];
    end
  end

  always_comb begin
    awready    = (w_state == W_IDLE) && !areset;
    wready     = (w_state == W_DATA) && !areset;
    bvalid     = (w_state == W_RESP) && !areset;
    bid        = bvalid ? w_id : 4'd0;
    bresp      = (bvalid && (w_err || w_mism)) ? 2'b10 : 2'b00;
    aw_hs      = awvalid && awready;
    w_hs       = wvalid && wready;
    w_hit      = (w_cnt == w_len);
    w_end      = w_hs && (wlast || w_hit);
    w_addr_nxt = w_incr ? w_addr + (32'd1 << w_size) : w_addr;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_end) w_next = (B_DELAY == 0) ? W_RESP : W_BWAIT;
      W_BWAIT: if (w_dly == 8'd0) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_id <= 4'd0; w_addr <= 32'd0; w_len <= 8'd0; w_size <= 3'd0;
      w_incr <= 1'b0; w_err <= 1'b0; w_mism <= 1'b0; w_cnt <= 8'd0;
      w_dly <= 8'd0;
    end else if (aw_hs) begin
      w_id <= awid; w_addr <= awaddr; w_len <= awlen; w_size <= awsize;
      w_incr <= (awburst == 2'b01);
      w_err  <= awburst[1] || (awlen > 8'd15);
      w_mism <= 1'b0; w_cnt <= 8'd0;
    end else if (w_hs) begin
      w_cnt  <= w_cnt + 8'd1;
      w_addr <= w_addr_nxt;
      if (w_end) begin
        w_mism <= (wlast != w_hit);
        w_dly  <= B_DLY_INIT;
      end
    end else if (w_state == W_BWAIT && w_dly != 8'd0) begin
      w_dly <= w_dly - 8'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset && w_hs && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[w_addr[ADDR_W+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule
